// File: rtl/batch_pingpong_if.sv
`default_nettype none
//==============================================================================
// batch_pingpong_if: valid/ready transaction stream (owner ID + dep bitmaps)
// rev 1.0
//==============================================================================
interface batch_pingpong_if #(
  parameter int ID_WIDTH  = 64,
  parameter int DEP_WIDTH = 1024
);
  logic                 tvalid;
  logic                 tready;
  logic [ID_WIDTH-1:0]  tdata_owner_programID;
  logic [DEP_WIDTH-1:0] tdata_read_dependencies;
  logic [DEP_WIDTH-1:0] tdata_write_dependencies;

  modport master (
    output tvalid,
    output tdata_owner_programID,
    output tdata_read_dependencies,
    output tdata_write_dependencies,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata_owner_programID,
    input  tdata_read_dependencies,
    input  tdata_write_dependencies,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/batch_pingpong.sv
`default_nettype none
//==============================================================================
// batch_pingpong: two-bank transaction batcher, closes on size/timeout/flush
// rev 1.0
//==============================================================================
module batch_pingpong #(
  parameter int ID_WIDTH       = 64,
  parameter int DEP_WIDTH      = 1024,
  parameter int MAX_BATCH_SIZE = 8,
  parameter int TIMEOUT_WIDTH  = 16,
  localparam int CNT_W         = $clog2(MAX_BATCH_SIZE) + 1
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic [CNT_W-1:0]         cfg_batch_size,
  input  wire logic [TIMEOUT_WIDTH-1:0] cfg_timeout_cycles,
  input  wire logic                     flush,
  batch_pingpong_if.slave               s_axis,
  batch_pingpong_if.master              m_axis,
  output logic                          m_axis_tlast,
  output logic [CNT_W-1:0]              m_axis_tuser_batch_size,
  output logic                          batch_completed,
  output logic [31:0]                   transactions_processed,
  output logic [31:0]                   batches_emitted,
  output logic [31:0]                   timeout_closes
);
  localparam int             IDX_W   = $clog2(MAX_BATCH_SIZE);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BATCH_SIZE);

  logic [ID_WIDTH-1:0]      owner_mem_q [2][MAX_BATCH_SIZE];
  logic [DEP_WIDTH-1:0]     rdep_mem_q  [2][MAX_BATCH_SIZE];
  logic [DEP_WIDTH-1:0]     wdep_mem_q  [2][MAX_BATCH_SIZE];

  logic [CNT_W-1:0]         count_q [2];
  logic [1:0]               full_q;
  logic                     fill_sel_q;
  logic                     drain_sel_q;
  logic [CNT_W-1:0]         rd_idx_q;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_q;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_d;
  logic                     batch_completed_q;
  logic [31:0]              tp_q;
  logic [31:0]              be_q;
  logic [31:0]              tc_q;

  logic [CNT_W-1:0]         thr_eff;
  logic [CNT_W-1:0]         fill_cnt;
  logic [CNT_W-1:0]         fill_cnt_d;
  logic                     fill_full;
  logic                     s_ready;
  logic                     accept;
  logic [TIMEOUT_WIDTH:0]   idle_inc;
  logic                     close_size;
  logic                     close_flush;
  logic                     close_timeout;
  logic                     close;
  logic [CNT_W-1:0]         drain_cnt;
  logic                     m_valid;
  logic                     m_last;
  logic                     fire;
  logic [IDX_W-1:0]         rd_addr;

  // Zero or oversized thresholds fall back to the bank depth.
  assign thr_eff    = (cfg_batch_size == '0 || cfg_batch_size > MAX_CNT) ? MAX_CNT : cfg_batch_size;

  assign fill_cnt   = count_q[fill_sel_q];
  assign fill_full  = full_q[fill_sel_q];
  assign s_ready    = rst_n && !fill_full;
  assign accept     = s_axis.tvalid && s_ready;
  assign fill_cnt_d = fill_cnt + CNT_W'(accept);
  assign idle_inc   = {1'b0, idle_cnt_q} + (TIMEOUT_WIDTH+1)'(1);

  // Full fill bank only exists while both banks are closed; never re-close it.
  assign close_size    = !fill_full && (fill_cnt_d != '0) && (fill_cnt_d >= thr_eff);
  assign close_flush   = !fill_full && flush && (fill_cnt_d != '0);
  assign close_timeout = !fill_full && (cfg_timeout_cycles != '0) && (fill_cnt != '0) &&
                         !accept && (idle_inc == {1'b0, cfg_timeout_cycles});
  assign close         = close_size || close_flush || close_timeout;

  assign drain_cnt = count_q[drain_sel_q];
  assign m_valid   = full_q[drain_sel_q];
  assign m_last    = m_valid && (rd_idx_q == drain_cnt - CNT_W'(1));
  assign fire      = m_valid && m_axis.tready;
  assign rd_addr   = rd_idx_q[IDX_W-1:0];

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (close || accept) begin
      idle_cnt_d = '0;
    end else if (fill_cnt != '0 && !fill_full && idle_cnt_q != '1) begin
      idle_cnt_d = idle_cnt_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q[0]        <= '0;
      count_q[1]        <= '0;
      full_q            <= '0;
      fill_sel_q        <= 1'b0;
      drain_sel_q       <= 1'b0;
      rd_idx_q          <= '0;
      idle_cnt_q        <= '0;
      batch_completed_q <= 1'b0;
      tp_q              <= '0;
      be_q              <= '0;
      tc_q              <= '0;
    end else begin
      idle_cnt_q        <= idle_cnt_d;
      batch_completed_q <= fire && m_last;
      if (accept) begin
        count_q[fill_sel_q] <= fill_cnt_d;
      end
      if (close) begin
        full_q[fill_sel_q] <= 1'b1;
        fill_sel_q         <= ~fill_sel_q;
      end
      if (close_timeout && !close_size && !close_flush) begin
        tc_q <= tc_q + 32'd1;
      end
      // Drain bank is always the other bank whenever the fill bank is open.
      if (fire) begin
        tp_q <= tp_q + 32'd1;
        if (m_last) begin
          count_q[drain_sel_q] <= '0;
          full_q[drain_sel_q]  <= 1'b0;
          rd_idx_q             <= '0;
          drain_sel_q          <= ~drain_sel_q;
          be_q                 <= be_q + 32'd1;
        end else begin
          rd_idx_q <= rd_idx_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      owner_mem_q[fill_sel_q][fill_cnt[IDX_W-1:0]] <= s_axis.tdata_owner_programID;
      rdep_mem_q[fill_sel_q][fill_cnt[IDX_W-1:0]]  <= s_axis.tdata_read_dependencies;
      wdep_mem_q[fill_sel_q][fill_cnt[IDX_W-1:0]]  <= s_axis.tdata_write_dependencies;
    end
  end

  assign s_axis.tready                   = s_ready;
  assign m_axis.tvalid                   = m_valid;
  assign m_axis.tdata_owner_programID    = m_valid ? owner_mem_q[drain_sel_q][rd_addr] : '0;
  assign m_axis.tdata_read_dependencies  = m_valid ? rdep_mem_q[drain_sel_q][rd_addr] : '0;
  assign m_axis.tdata_write_dependencies = m_valid ? wdep_mem_q[drain_sel_q][rd_addr] : '0;
  assign m_axis_tlast                    = m_last;
  assign m_axis_tuser_batch_size         = m_valid ? drain_cnt : '0;
  assign batch_completed                 = batch_completed_q;
  assign transactions_processed          = tp_q;
  assign batches_emitted                 = be_q;
  assign timeout_closes                  = tc_q;
endmodule
`default_nettype wire

// File: tb/tb_batch_pingpong.sv
`default_nettype none
//==============================================================================
// tb_batch_pingpong: directed + random scoreboard bench for batch_pingpong
// rev 1.0
//==============================================================================
module tb_batch_pingpong;
  localparam int ID_W  = 16;
  localparam int DEP_W = 32;
  localparam int MAX   = 8;
  localparam int TO_W  = 16;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [ID_W-1:0]  owner;
    logic [DEP_W-1:0] rd;
    logic [DEP_W-1:0] wr;
    logic             last;
    logic [CNT_W-1:0] user;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] cfg_batch_size = '0;
  logic [TO_W-1:0]  cfg_timeout = '0;
  logic             flush = 1'b0;
  logic             m_tlast;
  logic [CNT_W-1:0] m_tuser;
  logic             bc;
  logic [31:0]      tp;
  logic [31:0]      be;
  logic [31:0]      tc;

  always #5 clk = ~clk;

  batch_pingpong_if #(.ID_WIDTH(ID_W), .DEP_WIDTH(DEP_W)) s_if ();
  batch_pingpong_if #(.ID_WIDTH(ID_W), .DEP_WIDTH(DEP_W)) m_if ();

  batch_pingpong #(
    .ID_WIDTH(ID_W), .DEP_WIDTH(DEP_W), .MAX_BATCH_SIZE(MAX), .TIMEOUT_WIDTH(TO_W)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cfg_batch_size          (cfg_batch_size),
    .cfg_timeout_cycles      (cfg_timeout),
    .flush                   (flush),
    .s_axis                  (s_if.slave),
    .m_axis                  (m_if.master),
    .m_axis_tlast            (m_tlast),
    .m_axis_tuser_batch_size (m_tuser),
    .batch_completed         (bc),
    .transactions_processed  (tp),
    .batches_emitted         (be),
    .timeout_closes          (tc)
  );

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_bc  = 0;
  bit    jit_on = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one random transaction; the expected output beat is queued once accepted.
  task automatic drive_beat(input bit last, input logic [CNT_W-1:0] user, input bit flsh);
    beat_t b;
    bit    acc;
    b.owner = ID_W'($urandom());
    b.rd    = $urandom();
    b.wr    = $urandom();
    b.last  = last;
    b.user  = user;
    s_if.tvalid                   = 1'b1;
    s_if.tdata_owner_programID    = b.owner;
    s_if.tdata_read_dependencies  = b.rd;
    s_if.tdata_write_dependencies = b.wr;
    flush = flsh;
    acc = 1'b0;
    for (int t = 0; t < 3000 && !acc; t++) begin
      @(negedge clk);
      acc = s_if.tready;
      step();
    end
    s_if.tvalid = 1'b0;
    flush = 1'b0;
    chk("input_accepted", acc, 1);
    if (acc) exp_q.push_back(b);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 6000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_if.tvalid) break;
    end
    chk("drain_done", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit early;
    s_if.tvalid = 1'b0;
    s_if.tdata_owner_programID = '0;
    s_if.tdata_read_dependencies = '0;
    s_if.tdata_write_dependencies = '0;
    m_if.tready = 1'b0;

    fork
      begin : monitor
        beat_t cur;
        beat_t prev_b;
        beat_t e;
        bit    prev_stall;
        bit    prev_lf;
        prev_stall = 1'b0;
        prev_lf    = 1'b0;
        prev_b     = '0;
        forever begin
          @(negedge clk);
          cur.owner = m_if.tdata_owner_programID;
          cur.rd    = m_if.tdata_read_dependencies;
          cur.wr    = m_if.tdata_write_dependencies;
          cur.last  = m_tlast;
          cur.user  = m_tuser;
          if (rst_n && prev_stall) begin
            chk("hold_valid", m_if.tvalid, 1);
            chk("hold_beat", cur, prev_b);
          end
          if (rst_n) chk("batch_completed", bc, prev_lf);
          if (bc) n_bc++;
          if (rst_n && m_if.tvalid && m_if.tready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("beat", cur, e);
            end
          end
          prev_stall = rst_n && m_if.tvalid && !m_if.tready;
          prev_lf    = rst_n && m_if.tvalid && m_if.tready && m_tlast;
          prev_b     = cur;
        end
      end
      begin : jitter
        forever begin
          step();
          if (jit_on) m_if.tready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_owner", m_if.tdata_owner_programID, 0);
    chk("rst_bc", bc, 0);
    chk("rst_tp", tp, 0);
    chk("rst_be", be, 0);
    chk("rst_tc", tc, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_out_of_reset", s_if.tready, 1);
    step();

    // Threshold 4, back-to-back stream of 8
    cfg_batch_size = 4'd4;
    cfg_timeout = '0;
    m_if.tready = 1'b1;
    n_bc = 0;
    for (int i = 0; i < 8; i++) drive_beat(i % 4 == 3, 4'd4, 1'b0);
    wait_drain();
    chk("t1_batches", be, 2);
    chk("t1_processed", tp, 8);
    chk("t1_bc_pulses", n_bc, 2);
    step();

    // Idle timeout closes a 3-entry batch on the 10th idle cycle
    cfg_batch_size = 4'd8;
    cfg_timeout = 16'd10;
    for (int i = 0; i < 3; i++) drive_beat(i == 2, 4'd3, 1'b0);
    early = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      early |= m_if.tvalid;
    end
    chk("timeout_not_early", early, 0);
    @(negedge clk);
    chk("timeout_close", m_if.tvalid, 1);
    wait_drain();
    chk("t2_timeout_closes", tc, 1);
    chk("t2_batches", be, 3);
    step();

    // Output stalled: both banks fill, then drain in order
    cfg_timeout = '0;
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) drive_beat(i % 8 == 7, 4'd8, 1'b0);
    @(negedge clk);
    chk("both_full_ready", s_if.tready, 0);
    chk("both_full_valid", m_if.tvalid, 1);
    step();
    m_if.tready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (m_if.tvalid && m_if.tready && m_tlast) break;
    end
    chk("ready_at_tlast", s_if.tready, 0);
    @(negedge clk);
    chk("ready_after_tlast", s_if.tready, 1);
    wait_drain();
    chk("t3_processed", tp, 27);
    chk("t3_batches", be, 5);
    step();

    // Flush with the 2nd accept, then flush on an empty bank
    drive_beat(1'b0, 4'd2, 1'b0);
    drive_beat(1'b1, 4'd2, 1'b1);
    @(negedge clk);
    chk("flush_latency", m_if.tvalid, 1);
    wait_drain();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    early = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      early |= m_if.tvalid;
    end
    chk("empty_flush_no_output", early, 0);
    chk("t4_batches", be, 6);
    step();

    // Random stalls, 1000 transactions, threshold 5
    cfg_batch_size = 4'd5;
    jit_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) step();
      drive_beat(i % 5 == 4, 4'd5, 1'b0);
    end
    jit_on = 1'b0;
    step();
    m_if.tready = 1'b1;
    wait_drain();
    chk("t5_processed", tp, 1029);
    chk("t5_batches", be, 206);
    step();

    // Reset in the middle of a drain
    cfg_batch_size = 4'd4;
    m_if.tready = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(i == 3, 4'd4, 1'b0);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_m_tvalid", m_if.tvalid, 0);
    chk("midrst_s_tready", s_if.tready, 0);
    chk("midrst_tuser", m_tuser, 0);
    chk("midrst_tp", tp, 0);
    chk("midrst_be", be, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    cfg_batch_size = 4'd8;
    @(negedge clk);
    chk("ready_after_midrst", s_if.tready, 1);
    step();
    drive_beat(1'b0, 4'd2, 1'b0);
    drive_beat(1'b1, 4'd2, 1'b1);
    wait_drain();
    chk("t6_batches", be, 1);
    chk("t6_processed", tp, 2);
    chk("t6_timeouts", tc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
